// File: rtl/ixc_sfifo_port_arb_pkg.sv
// Shared types and constants for the sfifo return-path arbiter.
// Optional per-port completion counters are enabled with IXC_SFIFO_ARB_STATS_EN.
package ixc_sfifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/ixc_sfifo_port_arb_if.sv
// Port-side and upstream-channel signals of the sfifo return-path arbiter.
// The arbiter uses the master modport; the ports and transport use slave.
interface ixc_sfifo_port_arb_if #(
    parameter int NP = 4,
    parameter int DW = 512,
    parameter int LW = 4
);
    localparam int IW = $clog2(NP);

    logic [NP-1:0]    req;
    logic [NP*DW-1:0] pdata;
    logic [NP*LW-1:0] plen;
    logic [NP-1:0]    pack;
    logic [NP-1:0]    pdone;
    logic [DW-1:0]    CoData;
    logic             CoDataEn;
    logic [LW-1:0]    CoDataLen;
    logic             CoRdy;
    logic [IW-1:0]    gnt_id;
    logic             busy;

    modport master (
        input  req, pdata, plen, CoRdy,
        output pack, pdone, CoData, CoDataEn, CoDataLen, gnt_id, busy
    );

    modport slave (
        output req, pdata, plen, CoRdy,
        input  pack, pdone, CoData, CoDataEn, CoDataLen, gnt_id, busy
    );

endinterface

// File: rtl/ixc_sfifo_port_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, cyclically.
// Reusable by other fabric arbiters.
module ixc_rr_pick #(
    parameter int NP = 4,
    parameter int IW = $clog2(NP)
) (
    input  logic [NP-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [NP-1:0] o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_pos;

    // NOTE: every output and temporary gets a default first so no path can infer a latch.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = |i_req;
        w_pos = 0;
        // Scan from the farthest offset down so the closest request to i_ptr wins last.
        for (int k = NP - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NP) begin
                w_pos = w_pos - NP;
            end
            if (i_req[w_pos]) begin
                o_gnt        = '0;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/ixc_sfifo_port_arb.sv
// Round-robin return-path arbiter: locks the upstream channel to one sfifo port per packet.
// Define IXC_SFIFO_ARB_STATS_EN to add saturating per-port completed-packet counters.
module ixc_sfifo_port_arb
    import ixc_sfifo_arb_pkg::*;
#(
    parameter int NP = 4,
    parameter int DW = 512,
    parameter int LW = 4
) (
    input  logic                  fclk,
    input  logic                  frstN,
    ixc_sfifo_port_arb_if.master  arb_if
`ifdef IXC_SFIFO_ARB_STATS_EN
    ,
    output logic [NP*STAT_W-1:0]  stats
`endif
);

    localparam int IW = $clog2(NP);

    arb_state_e    r_state, w_state_nxt;
    logic [IW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [LW-1:0] r_cnt, w_cnt_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic [NP-1:0] w_pack, w_pdone;
    logic [NP-1:0] w_pick_gnt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic [LW-1:0] w_plen_sel;

    ixc_rr_pick #(.NP(NP), .IW(IW)) u_pick (
        .i_req (arb_if.req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // One-hot AND-OR select of the winner's length field.
    always_comb begin
        w_plen_sel = '0;
        for (int i = 0; i < NP; i++) begin
            if (w_pick_gnt[i]) begin
                w_plen_sel = w_plen_sel | arb_if.plen[i*LW +: LW];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_pack       = '0;
        w_pdone      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt  = ST_XFER;
                    w_gnt_id_nxt = w_pick_idx;
                    w_cnt_nxt    = w_plen_sel;
                    w_len_nxt    = w_plen_sel;
                end
            end
            ST_XFER: begin
                if (arb_if.CoRdy) begin
                    w_pack[r_gnt_id] = 1'b1;
                    if (r_cnt == '0) begin
                        w_pdone[r_gnt_id] = 1'b1;
                        w_ptr_nxt   = (r_gnt_id == IW'(NP - 1)) ? '0 : r_gnt_id + IW'(1);
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - LW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fclk) begin
        if (!frstN) begin
            r_state  <= ST_IDLE;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
        end
    end

    assign arb_if.CoDataEn  = (r_state == ST_XFER);
    assign arb_if.busy      = (r_state == ST_XFER);
    assign arb_if.gnt_id    = r_gnt_id;
    assign arb_if.CoDataLen = r_len;
    assign arb_if.CoData    = arb_if.pdata[r_gnt_id*DW +: DW];
    assign arb_if.pack      = w_pack;
    assign arb_if.pdone     = w_pdone;

`ifdef IXC_SFIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stats [NP];

    // NOTE: the counter array is small and architecturally visible, so every entry is reset.
    always_ff @(posedge fclk) begin
        if (!frstN) begin
            for (int i = 0; i < NP; i++) begin
                r_stats[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (w_pdone[i] && (r_stats[i] != STAT_MAX)) begin
                    r_stats[i] <= r_stats[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_stats
        assign stats[g*STAT_W +: STAT_W] = r_stats[g];
    end
`endif

endmodule

// File: doc/ixc_sfifo_port_arb.md
# ixc_sfifo_port_arb

Return-path arbiter that shares one upstream output channel (`CoData`/`CoDataEn`/`CoDataLen`) among `NP` sfifo ports. Each port presents a pending multi-beat packet; the arbiter grants one port at a time in round-robin order and locks the channel to it until its last beat is accepted. It sits between the per-port sfifo instances and the transport channel, in the same transaction-based emulation fabric.

## Interface
- `NP`, 4, number of requesting ports (2..16)
- `DW`, 512, data beat width
- `LW`, 4, packet length field width (value = beats-1)
- `fclk`  in  1  sole clock, all state on rising edge
- `frstN`  in  1  reset, synchronous, active-low
- `req`  in  NP  port i has a packet pending; sampled only in IDLE
- `pdata`  in  NP*DW  port i current beat at `[i*DW +: DW]`; held stable until `pack[i]`
- `plen`  in  NP*LW  port i packet length-1 at `[i*LW +: LW]`; sampled at grant
- `pack`  out  NP  one-hot pulse: port i beat consumed this cycle
- `pdone`  out  NP  one-hot pulse: port i last beat consumed this cycle
- `CoData`  out  DW  current beat, `pdata` slice of owner
- `CoDataEn`  out  1  beat valid
- `CoDataLen`  out  LW  captured `plen` of owner, constant for whole packet
- `CoRdy`  in  1  upstream accepts beat when `CoDataEn & CoRdy`
- `gnt_id`  out  $clog2(NP)  owner index
- `busy`  out  1  state is XFER
- `stats`  out  NP*16  per-port completed-packet counters (only with `IXC_SFIFO_ARB_STATS_EN`)

## Operation
- States: IDLE, XFER. Registered: state, `gnt_id`, `CoDataLen`, beat counter `cnt` (LW bits), rotate pointer `ptr`.
- IDLE: if `|req`, pick first set bit at or after `ptr` cyclically; next cycle: XFER, `gnt_id`=winner, `cnt`=`CoDataLen`=`plen[winner]`. No req: stay IDLE.
- XFER: `CoDataEn`=1; `CoData`=`pdata[gnt_id]` (combinational mux).
  - `CoRdy`=1: `pack[gnt_id]`=1; if `cnt`==0 then `pdone[gnt_id]`=1, `ptr`=(`gnt_id`+1) mod NP, go IDLE; else `cnt`-=1.
  - `CoRdy`=0: hold everything, no pulses.
- `req` ignored during XFER; deassertion mid-packet does not abort it.
- `plen`=0 is a single-beat packet; `plen`=2^LW-1 is 2^LW beats; `cnt` never wraps.
- `ptr` wrap: `gnt_id`=NP-1 sets `ptr`=0.
- `pack`, `pdone` are zero outside XFER; at most one bit set.
- Reset values: state IDLE, `ptr`=0, `gnt_id`=0, `cnt`=0, `CoDataLen`=0, `CoDataEn`=0, `busy`=0, `pack`=0, `pdone`=0, `stats`=0; `CoData` = `pdata[0]` (don't-care while `CoDataEn`=0).
- Reset mid-packet: packet abandoned with no `pdone`; ports must discard partial state on the same reset.

## Timing
- Grant latency: `req` seen in IDLE at cycle t, first `CoDataEn` at t+1.
- Throughput with `CoRdy`=1: plen+2 cycles per packet (one IDLE bubble between packets).
- `pack`/`pdone` are combinational from registered state and `CoRdy`, same cycle as the accepted beat.
- `CoDataEn`, `gnt_id`, `CoDataLen`, `busy` are direct register outputs.

## Configuration
- `IXC_SFIFO_ARB_STATS_EN` defined: per-port 16-bit counter increments on `pdone[i]` and saturates at 0xFFFF. Counters are cleared only by reset. `stats[i*16 +: 16]` is a register output.
- Not defined: no `stats` port, no counters; all other behaviour is identical.

## Structure
- Package `ixc_sfifo_arb_pkg`: state enum (IDLE, XFER), `STAT_W`=16, `STAT_MAX`=16'hFFFF.
- Sub-module `ixc_rr_pick`: combinational, NP-bit `req` plus `ptr` in, one-hot grant, index and `any` out. It is reusable by other fabric arbiters.

## Test plan
- Port 2 only, `plen`=3, `CoRdy`=1 -> `CoDataEn` from next cycle for 4 cycles, `gnt_id`=2, `CoDataLen`=3, `pack[2]` pulsed 4 times, `pdone[2]` on 4th beat, then IDLE.
- All 4 ports request continuously, `plen`=0, from reset -> grants in order 0,1,2,3,0, one per 2 cycles.
- Port 1 `plen`=5 with `CoRdy` low 5 cycles after beat 2 -> `CoData`/`CoDataEn`/`gnt_id` stable, no `pack`; the packet resumes and completes with 6 total acks.
- Port 3 drops `req` after beat 1 of a `plen`=7 packet -> all 8 beats still transferred, `pdone[3]` asserted.
- `frstN` low for 1 cycle during beat 2 of a port-1 packet -> next cycle `CoDataEn`=0, `busy`=0, no `pdone`; with ports 1 and 2 requesting, the next grant goes to port 1 (`ptr`=0).
- With `IXC_SFIFO_ARB_STATS_EN`: 70000 single-beat packets on port 0 -> `stats[15:0]`=0xFFFF and holds; other counters are 0.
